// File: rtl/sparse_stream_arbiter.sv
// sparse_stream_arbiter: merges NUM_IN 17-bit ready/valid token streams onto one registered
// output. The grant is held for a whole stream and released on DONE_TOKEN. The next grant is
// chosen round-robin.
// Optional feature: define SPARSE_ARB_TIMEOUT_EN to release a grant whose input stays idle
// for TIMEOUT cycles.
module sparse_stream_arbiter #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned TX_NUM     = 1,
  parameter logic [16:0] DONE_TOKEN = 17'h10100,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [17*NUM_IN-1:0]      in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [16:0]               out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_IN)-1:0] out_src,
  output logic                      done
);

  localparam int unsigned PtrW = $clog2(NUM_IN);
  localparam int unsigned CntW = $clog2(TX_NUM + 1);

  typedef enum logic [1:0] {StIdle, StArb, StLock, StDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   grant_q, grant_d;
  logic [CntW-1:0]   done_cnt_q [NUM_IN];
  logic [CntW-1:0]   done_cnt_d [NUM_IN];
  logic [NUM_IN-1:0] finished_q, finished_d;
  logic              out_valid_q, out_valid_d;
  logic [16:0]       out_data_q, out_data_d;
  logic [PtrW-1:0]   out_src_q, out_src_d;

`ifdef SPARSE_ARB_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  logic            arb_hit;
  logic [PtrW-1:0] arb_idx;
  logic [PtrW-1:0] scan_idx;
  logic [16:0]     gnt_tok;
  logic            gnt_valid;
  logic            can_load;
  logic            xfer;
  logic [PtrW-1:0] grant_inc;

  // Round-robin scan from rr_ptr upward, first valid and unfinished input wins
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      scan_idx = PtrW'((32'(rr_ptr_q) + k) % NUM_IN);
      if (!arb_hit && in_valid[scan_idx] && !finished_q[scan_idx]) begin
        arb_hit = 1'b1;
        arb_idx = scan_idx;
      end
    end
  end

  // Select the granted input's token and derive the handshake
  always_comb begin
    gnt_tok = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant_q == PtrW'(i)) gnt_tok = in_data[17*i +: 17];
    end
    gnt_valid = in_valid[grant_q];
    can_load  = !out_valid_q || out_ready;
    grant_inc = PtrW'((32'(grant_q) + 32'd1) % NUM_IN);
    in_ready  = '0;
    // Ready is masked during flush so no token is accepted and then dropped
    if (state_q == StLock && !flush) in_ready[grant_q] = can_load;
    xfer = (state_q == StLock) && !flush && gnt_valid && can_load;
  end

  // Next-state logic for the FSM, counters and output register
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    done_cnt_d  = done_cnt_q;
    finished_d  = finished_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
`ifdef SPARSE_ARB_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
`endif

    // Load and drain in the same cycle replaces the contents without a bubble
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_tok;
      out_src_d   = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: state_d = StArb;
      StArb: begin
`ifdef SPARSE_ARB_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (arb_hit) begin
          grant_d = arb_idx;
          state_d = StLock;
        end
      end
      StLock: begin
        if (xfer) begin
`ifdef SPARSE_ARB_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
          if (gnt_tok == DONE_TOKEN) begin
            if (32'(done_cnt_q[grant_q]) < TX_NUM) begin
              done_cnt_d[grant_q] = done_cnt_q[grant_q] + CntW'(1);
            end
            if (32'(done_cnt_d[grant_q]) >= TX_NUM) finished_d[grant_q] = 1'b1;
            rr_ptr_d = grant_inc;
            state_d  = (&finished_d) ? StDone : StArb;
          end
        end
`ifdef SPARSE_ARB_TIMEOUT_EN
        else if (!gnt_valid) begin
          // Idle input gives up the grant but stays eligible
          if (32'(idle_cnt_q) + 32'd1 >= TIMEOUT) begin
            idle_cnt_d = '0;
            rr_ptr_d   = grant_inc;
            state_d    = StArb;
          end else begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
          end
        end
`endif
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d     = StIdle;
      rr_ptr_d    = '0;
      grant_d     = '0;
      finished_d  = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_src_d   = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) done_cnt_d[i] = '0;
`ifdef SPARSE_ARB_TIMEOUT_EN
      idle_cnt_d  = '0;
`endif
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      finished_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) done_cnt_q[i] <= '0;
`ifdef SPARSE_ARB_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      finished_q  <= finished_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      for (int unsigned i = 0; i < NUM_IN; i++) done_cnt_q[i] <= done_cnt_d[i];
`ifdef SPARSE_ARB_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign done      = (state_q == StDone) && !out_valid_q;

endmodule

// File: tb/tb_sparse_stream_arbiter.sv
// Directed bench for sparse_stream_arbiter (NUM_IN=4, TX_NUM=2, TIMEOUT=8).
// Per-input token lists are replayed by the bench and every output handshake is logged.
module tb_sparse_stream_arbiter;

  localparam int unsigned NumIn   = 4;
  localparam int unsigned TxNum   = 2;
  localparam int unsigned Timeout = 8;
  localparam logic [16:0] DoneTok = 17'h10100;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic [17*NumIn-1:0] in_data;
  logic [NumIn-1:0]   in_valid;
  logic [NumIn-1:0]   in_ready;
  logic [16:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_src;
  logic               done;

  sparse_stream_arbiter #(
    .NUM_IN    (NumIn),
    .TX_NUM    (TxNum),
    .DONE_TOKEN(DoneTok),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src  (out_src),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [16:0]      tok_mem [NumIn][16];
  int               tok_len [NumIn];
  int               tok_idx [NumIn];
  logic [NumIn-1:0] en;
  int               ready_mode;  // 0: always ready, 1: pattern 1,0,0,1, 2: never ready
  int               rdy_phase;
  logic [16:0]      obs_data [64];
  int               obs_src [64];
  int               obs_cyc [64];
  int               obs_n;
  int               cyc;
  int               checks;
  int               failures;

  task automatic apply();
    for (int i = 0; i < NumIn; i++) begin
      if (en[i] && tok_idx[i] < tok_len[i]) begin
        in_valid[i] = 1'b1;
        in_data[17*i +: 17] = tok_mem[i][tok_idx[i]];
      end else begin
        in_valid[i] = 1'b0;
        in_data[17*i +: 17] = '0;
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
      default: out_ready = 1'b0;
    endcase
    #1;
  endtask

  // One clock: log handshakes seen before the edge, then advance sources at the negedge
  task automatic cycle();
    logic [NumIn-1:0] hs;
    hs = in_valid & in_ready;
    if (out_valid && out_ready && obs_n < 64) begin
      obs_data[obs_n] = out_data;
      obs_src[obs_n]  = int'(out_src);
      obs_cyc[obs_n]  = cyc;
      obs_n++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rdy_phase++;
    for (int i = 0; i < NumIn; i++) if (hs[i]) tok_idx[i]++;
    apply();
  endtask

  task automatic reset_srcs();
    en = '0;
    for (int i = 0; i < NumIn; i++) begin
      tok_len[i] = 0;
      tok_idx[i] = 0;
    end
    obs_n = 0;
  endtask

  task automatic do_flush();
    reset_srcs();
    ready_mode = 0;
    flush = 1'b1;
    apply();
    cycle();
    flush = 1'b0;
    apply();
  endtask

  task automatic run_until(input int n, input int max_cyc, input string name);
    int k;
    k = 0;
    while (obs_n < n && k < max_cyc) begin
      cycle();
      k++;
    end
    checks++;
    if (obs_n < n) begin
      $display("FAIL %s timeout: got %0d tokens, required %0d", name, obs_n, n);
      failures++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    reset_srcs();
    ready_mode = 0;
    rdy_phase = 0;
    en = '1;
    for (int i = 0; i < NumIn; i++) begin
      tok_mem[i][0] = 17'h1;
      tok_len[i] = 1;
    end
    apply();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); failures++;
    end
    checks++;
    if (out_data !== 17'h0) begin
      $display("FAIL reset_out_data got=%h exp=0", out_data); failures++;
    end
    checks++;
    if (out_src !== 2'd0) begin
      $display("FAIL reset_out_src got=%0d exp=0", out_src); failures++;
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      $display("FAIL reset_in_ready got=%b exp=0000", in_ready); failures++;
    end
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL reset_done got=%b exp=0", done); failures++;
    end
    rst_n = 1'b1;
    reset_srcs();
    apply();
  endtask

  task automatic test_single_stream();
    logic [16:0] exp_d [5];
    int          exp_s [5];
    exp_d = '{17'h5, 17'h6, DoneTok, 17'h9, DoneTok};
    exp_s = '{0, 0, 0, 1, 1};
    tok_mem[0][0] = 17'h5; tok_mem[0][1] = 17'h6; tok_mem[0][2] = DoneTok; tok_len[0] = 3;
    tok_mem[1][0] = 17'h9; tok_mem[1][1] = DoneTok; tok_len[1] = 2;
    en = 4'b0011;
    apply();
    run_until(5, 40, "single_stream");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= obs_n || obs_data[k] !== exp_d[k] || obs_src[k] != exp_s[k]) begin
        $display("FAIL single_tok%0d got=%h/src%0d exp=%h/src%0d", k, obs_data[k], obs_src[k],
                 exp_d[k], exp_s[k]);
        failures++;
      end
    end
    checks++;
    if (obs_cyc[1] - obs_cyc[0] != 1) begin
      $display("FAIL single_throughput gap got=%0d exp=1", obs_cyc[1] - obs_cyc[0]); failures++;
    end
    checks++;
    if (obs_cyc[3] - obs_cyc[2] != 2) begin
      $display("FAIL single_bubble gap got=%0d exp=2", obs_cyc[3] - obs_cyc[2]); failures++;
    end
    cycle();
    cycle();
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL single_not_done got done=%b valid=%b exp 0/0", done, out_valid); failures++;
    end
  endtask

  task automatic test_fairness();
    logic [16:0] exp;
    int          k;
    do_flush();
    for (int i = 0; i < NumIn; i++) begin
      for (int s = 0; s < 2; s++) begin
        for (int j = 0; j < 4; j++) begin
          tok_mem[i][s*4+j] = (j == 3) ? DoneTok : 17'(i*16 + s*4 + j + 1);
        end
      end
      tok_len[i] = 8;
    end
    en = '1;
    apply();
    run_until(31, 80, "fairness");
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL fair_done_early got=%b exp=0", done); failures++;
    end
    run_until(32, 4, "fairness_last");
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL fair_done got=%b exp=1", done); failures++;
    end
    k = 0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NumIn; i++) begin
        for (int j = 0; j < 4; j++) begin
          exp = (j == 3) ? DoneTok : 17'(i*16 + s*4 + j + 1);
          checks++;
          if (k >= obs_n || obs_data[k] !== exp || obs_src[k] != i) begin
            $display("FAIL fair_tok%0d got=%h/src%0d exp=%h/src%0d", k, obs_data[k], obs_src[k],
                     exp, i);
            failures++;
          end
          k++;
        end
      end
    end
    cycle();
    checks++;
    if (in_ready !== 4'b0000 || obs_n != 32) begin
      $display("FAIL fair_idle got ready=%b n=%0d exp 0000/32", in_ready, obs_n); failures++;
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp_d [4];
    logic [16:0] held;
    logic        prev_stall;
    exp_d = '{17'h11, 17'h12, 17'h13, DoneTok};
    do_flush();
    for (int j = 0; j < 4; j++) tok_mem[0][j] = exp_d[j];
    tok_len[0] = 4;
    en = 4'b0001;
    ready_mode = 1;
    rdy_phase = 0;
    prev_stall = 1'b0;
    held = '0;
    apply();
    for (int c = 0; c < 24; c++) begin
      if (prev_stall) begin
        checks++;
        if (out_data !== held) begin
          $display("FAIL bp_stable got=%h exp=%h", out_data, held); failures++;
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 4'b0000) begin
          $display("FAIL bp_in_ready got=%b exp=0000", in_ready); failures++;
        end
        held = out_data;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      cycle();
    end
    checks++;
    if (obs_n != 4) begin
      $display("FAIL bp_count got=%0d exp=4", obs_n); failures++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= obs_n || obs_data[k] !== exp_d[k] || obs_src[k] != 0) begin
        $display("FAIL bp_tok%0d got=%h/src%0d exp=%h/src0", k, obs_data[k], obs_src[k],
                 exp_d[k]);
        failures++;
      end
    end
    ready_mode = 0;
    apply();
  endtask

  task automatic test_stop_tokens();
    logic [16:0] exp_d [6];
    int          exp_s [6];
    exp_d = '{17'h1, 17'h10000, 17'h2, DoneTok, 17'h21, DoneTok};
    exp_s = '{0, 0, 0, 0, 1, 1};
    do_flush();
    for (int j = 0; j < 4; j++) tok_mem[0][j] = exp_d[j];
    tok_len[0] = 4;
    tok_mem[1][0] = 17'h21; tok_mem[1][1] = DoneTok; tok_len[1] = 2;
    en = 4'b0011;
    apply();
    run_until(6, 40, "stop_tokens");
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= obs_n || obs_data[k] !== exp_d[k] || obs_src[k] != exp_s[k]) begin
        $display("FAIL stop_tok%0d got=%h/src%0d exp=%h/src%0d", k, obs_data[k], obs_src[k],
                 exp_d[k], exp_s[k]);
        failures++;
      end
    end
  endtask

  task automatic test_flush_mid_stream();
    do_flush();
    // input1 completes one stream so rr_ptr and done_cnt[1] are non-zero before flush
    tok_mem[1][0] = 17'h51; tok_mem[1][1] = DoneTok; tok_len[1] = 2;
    en = 4'b0010;
    apply();
    run_until(2, 20, "flush_pre1");
    for (int j = 0; j < 4; j++) tok_mem[0][j] = 17'(17'h31 + j);
    tok_mem[0][4] = DoneTok;
    tok_len[0] = 5;
    en = 4'b0011;
    apply();
    run_until(4, 20, "flush_pre2");
    checks++;
    if (out_valid !== 1'b1 || out_data !== 17'h33) begin
      $display("FAIL flush_pre got valid=%b data=%h exp 1/00033", out_valid, out_data);
      failures++;
    end
    ready_mode = 2;
    flush = 1'b1;
    apply();
    cycle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      $display("FAIL flush_clear got valid=%b ready=%b exp 0/0000", out_valid, in_ready);
      failures++;
    end
    flush = 1'b0;
    ready_mode = 0;
    reset_srcs();
    for (int i = 0; i < NumIn; i++) begin
      tok_mem[i][0] = DoneTok;
      tok_mem[i][1] = DoneTok;
      tok_len[i] = 2;
    end
    en = '1;
    apply();
    run_until(8, 60, "flush_post");
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= obs_n || obs_data[k] !== DoneTok || obs_src[k] != k % 4) begin
        $display("FAIL flush_post_tok%0d got=%h/src%0d exp=%h/src%0d", k, obs_data[k],
                 obs_src[k], DoneTok, k % 4);
        failures++;
      end
    end
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL flush_post_done got=%b exp=1", done); failures++;
    end
  endtask

  task automatic test_timeout();
    logic [16:0] exp_d [4];
    int          exp_s [4];
    do_flush();
    tok_mem[0][0] = 17'h61; tok_len[0] = 1;
    tok_mem[1][0] = 17'h71; tok_mem[1][1] = DoneTok; tok_len[1] = 2;
    en = 4'b0011;
    apply();
`ifdef SPARSE_ARB_TIMEOUT_EN
    exp_d = '{17'h61, 17'h71, DoneTok, DoneTok};
    exp_s = '{0, 1, 1, 0};
    run_until(3, 40, "timeout_release");
    checks++;
    if (obs_cyc[1] - obs_cyc[0] != 10) begin
      $display("FAIL timeout_gap got=%0d exp=10", obs_cyc[1] - obs_cyc[0]); failures++;
    end
    tok_mem[0][1] = DoneTok;
    tok_len[0] = 2;
    apply();
`else
    exp_d = '{17'h61, DoneTok, 17'h71, DoneTok};
    exp_s = '{0, 0, 1, 1};
    for (int c = 0; c < 30; c++) cycle();
    checks++;
    if (obs_n != 1 || in_ready[1] !== 1'b0) begin
      $display("FAIL hold_grant got n=%0d ready1=%b exp 1/0", obs_n, in_ready[1]); failures++;
    end
    tok_mem[0][1] = DoneTok;
    tok_len[0] = 2;
    apply();
`endif
    run_until(4, 40, "timeout_final");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= obs_n || obs_data[k] !== exp_d[k] || obs_src[k] != exp_s[k]) begin
        $display("FAIL timeout_tok%0d got=%h/src%0d exp=%h/src%0d", k, obs_data[k], obs_src[k],
                 exp_d[k], exp_s[k]);
        failures++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    in_data  = '0;
    in_valid = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_stream();
    test_fairness();
    test_backpressure();
    test_stop_tokens();
    test_flush_mid_stream();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sparse_stream_arbiter.md
Name: sparse_stream_arbiter

Overview:
- Merges NUM_IN 17-bit sparse token streams (ready/valid) onto one output stream for a shared downstream tile port.
- Grant is locked to one input for a whole stream: it is held until that input sends a DONE token (17'h10100), then passes round-robin to the next input.
- Sits between tile-level stream sources (memory/stream tiles) and a single consumer.
- Asserts done once every input has delivered TX_NUM DONE tokens.

Parameters:
- NUM_IN, 4: number of input streams, 2..16.
- TX_NUM, 1: DONE tokens each input must deliver before it is finished.
- DONE_TOKEN, 17'h10100: token value that ends a stream and releases the grant.
- TIMEOUT, 64: idle-cycle limit, used only with the optional feature.

Ports:
- clk  input  1  clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear; while high, the block is held in IDLE.
- in_data  input  17*NUM_IN  packed input tokens; input i occupies bits [17*i+16 : 17*i].
- in_valid  input  NUM_IN  per-input valid.
- in_ready  output  NUM_IN  per-input ready.
- out_data  output  17  registered output token.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_src  output  $clog2(NUM_IN)  index of the input that supplied out_data.
- done  output  1  all inputs finished and output register empty.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rr_ptr=0, grant=0, all done_cnt=0, finished=0, out_valid=0, out_data=0, out_src=0, in_ready=0, done=0.
- flush high: same clear as reset, applied synchronously; any token in the output register is dropped.
- States:
  - IDLE: leave to ARB on the first cycle with flush low.
  - ARB: scan inputs from rr_ptr upward, wrapping, for the first i with in_valid[i]=1 and finished[i]=0. On a hit, grant<=i and go to LOCK. With no hit, stay in ARB. No transfer happens in ARB, so each grant costs one bubble cycle.
  - LOCK: in_ready[grant] = can_load, where can_load = !out_valid || out_ready. All other in_ready bits are 0.
    - A transfer (in_valid & in_ready) loads out_data, out_src and out_valid=1 on the next edge. Latency is 1 cycle; throughput is 1 token/cycle.
    - Transfer of DONE_TOKEN: done_cnt[grant]++. If the count reaches TX_NUM, set finished[grant]. Then rr_ptr <= (grant+1) mod NUM_IN. Go to DONE if all inputs are finished, otherwise go to ARB.
    - Other control tokens (bit16=1, e.g. stop tokens 17'h1000x) pass through and do not release the grant.
  - DONE: all in_ready=0. Stay until flush or reset.
- Output register: when out_valid=1, out_ready=1 and no new load occurs, clear out_valid. A simultaneous drain and load replaces the contents without a bubble. out_data is held stable while out_valid=1 and out_ready=0.
- done = (state==DONE) && !out_valid, decoded from registers.
- Widths: done_cnt is $clog2(TX_NUM+1) bits and saturates at TX_NUM. Increments and rr_ptr wrap are computed at full width.
- in_valid on a finished or ungranted input is ignored; its in_ready stays 0.
- NUM_IN inputs all finished in the same cycle cannot happen, because only one input transfers per cycle.

Optional Feature:
- Macro: SPARSE_ARB_TIMEOUT_EN.
- Defined: in LOCK, an idle counter increments every cycle in which in_valid[grant]=0 and resets to 0 on any transfer. When it reaches TIMEOUT:
  - grant is released to ARB with rr_ptr <= grant+1;
  - done_cnt is unchanged;
  - the input stays eligible.
- Not defined: no counter; the grant is held indefinitely until DONE_TOKEN arrives.

Test Plan:
- Single stream: NUM_IN=2, TX_NUM=1; input0 sends 5, 6, 17'h10100 with out_ready=1 while input1 is idle, then input1 sends 9, 17'h10100 → out shows 5, 6, 10100 with src 0, a 1-cycle bubble, then 9, 10100 with src 1. done rises the cycle after the last token drains.
- Round-robin fairness: all 4 inputs valid continuously, each stream 3 data tokens + DONE, TX_NUM=2 → grant order 0, 1, 2, 3, 0, 1, 2, 3; done=1 after 32 output tokens.
- Backpressure: out_ready toggles 1, 0, 0, 1 during a stream → no token lost or duplicated, out_data stable while stalled, in_ready low while out_valid=1 and out_ready=0.
- Stop tokens: input0 sends 1, 17'h10000, 2, 17'h10100 while input1 is valid → grant stays on 0 through 17'h10000 and switches only after 17'h10100.
- Flush mid-stream: assert flush with out_valid=1 after 2 tokens → out_valid=0 and in_ready=0 next cycle; after flush falls, the first grant goes to input 0 and done_cnt restarts at 0.
- Timeout (SPARSE_ARB_TIMEOUT_EN, TIMEOUT=8): input0 sends 1 token then idles while input1 is valid → input0 is released after 8 idle cycles and input1 is granted; input0 later completes and done rises.
